// File: rtl/timer0_peripheral.sv
// TMR0 timer/counter with 8-bit prescaler, OPTION_REG and synchronised external clock input.
// TMR0 decodes at 0x001/0x101 and OPTION_REG at 0x081/0x181 on the core's peripheral bus.
module timer0_peripheral #(
  parameter int CLKS_PER_INSTR = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       t0cki,
  output logic [7:0] data_out,
  output logic       rd_hit,
  output logic       t0if_set
);

  localparam int               DIV_W    = (CLKS_PER_INSTR > 1) ? $clog2(CLKS_PER_INSTR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_INSTR - 1);

  logic [7:0]             tmr0_q, tmr0_d;
  logic [7:0]             option_q, option_d;
  logic [7:0]             pre_q, pre_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q;
  logic [1:0]             inh_q, inh_d;
  logic                   t0if_q, t0if_d;

  logic       sel_tmr0, sel_opt, wr_tmr0, wr_opt;
  logic       t0cs, t0se, psa;
  logic [2:0] ps;
  logic       tcy_tick, sync_last, ext_tick, src_tick;
  logic [7:0] pre_inc, low_mask;
  logic       pre_tick, inc_tick;

  assign sel_tmr0 = (addr == 9'h001) || (addr == 9'h101);
  assign sel_opt  = (addr == 9'h081) || (addr == 9'h181);
  assign wr_tmr0  = wr_en && sel_tmr0;
  assign wr_opt   = wr_en && sel_opt;

  assign t0cs = option_q[5];
  assign t0se = option_q[4];
  assign psa  = option_q[3];
  assign ps   = option_q[2:0];

  always_comb begin
    data_out = 8'h00;
    if (sel_tmr0)     data_out = tmr0_q;
    else if (sel_opt) data_out = option_q;
  end

  assign rd_hit   = sel_tmr0 || sel_opt;
  assign t0if_set = t0if_q;

  assign tcy_tick = (div_q == DIV_LAST);
  assign div_d    = tcy_tick ? '0 : div_q + 1'b1;

  // edge_q holds the previous synchronised level, so pin-to-tick latency is SYNC_STAGES+1
  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      assign sync_d = {sync_q[SYNC_STAGES-2:0], t0cki};
    end else begin : g_sync_single
      assign sync_d = t0cki;
    end
  endgenerate

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign ext_tick  = t0se ? (~sync_last & edge_q) : (sync_last & ~edge_q);
  assign src_tick  = t0cs ? ext_tick : tcy_tick;

  // Divide-by-2^(PS+1): fires when bit PS is set and every lower bit is clear
  assign pre_inc  = pre_q + 8'd1;
  assign low_mask = (8'd1 << ps) - 8'd1;
  assign pre_tick = pre_inc[ps] && ((pre_inc & low_mask) == 8'h00);
  assign inc_tick = psa ? src_tick : (src_tick && pre_tick);

  always_comb begin
    tmr0_d   = tmr0_q;
    option_d = option_q;
    pre_d    = pre_q;
    inh_d    = inh_q;
    t0if_d   = 1'b0;

    if (!psa && src_tick) pre_d = pre_inc;
    if (tcy_tick && (inh_q != 2'd0)) inh_d = inh_q - 2'd1;

    // A TMR0 write takes priority over a coincident increment and suppresses its overflow
    if (wr_tmr0) begin
      tmr0_d = data_in;
      pre_d  = 8'h00;
      inh_d  = 2'd2;
    end else if (inc_tick && (inh_q == 2'd0)) begin
      tmr0_d = tmr0_q + 8'd1;
      t0if_d = (tmr0_q == 8'hFF);
    end

    if (wr_opt) option_d = data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr0_q   <= 8'h00;
      option_q <= 8'hFF;
      pre_q    <= 8'h00;
      div_q    <= '0;
      sync_q   <= '0;
      edge_q   <= 1'b0;
      inh_q    <= 2'd0;
      t0if_q   <= 1'b0;
    end else begin
      tmr0_q   <= tmr0_d;
      option_q <= option_d;
      pre_q    <= pre_d;
      div_q    <= div_d;
      sync_q   <= sync_d;
      edge_q   <= sync_last;
      inh_q    <= inh_d;
      t0if_q   <= t0if_d;
    end
  end

endmodule

// File: tb/tb_timer0_peripheral.sv
// Bench for timer0_peripheral: expected read values are queued when stimulus is
// applied and popped at the sampling point, cycle-aligned to the Tcy divider phase.
module tb_timer0_peripheral;

  logic       clk;
  logic       rst;
  logic [8:0] addr;
  logic [7:0] data_in;
  logic       wr_en;
  logic       t0cki;
  logic [7:0] data_out;
  logic       rd_hit;
  logic       t0if_set;

  int         vecs;
  int         errs;
  int         pulses;
  int         cyc;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  timer0_peripheral #(.CLKS_PER_INSTR(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .t0cki    (t0cki),
    .data_out (data_out),
    .rd_hit   (rd_hit),
    .t0if_set (t0if_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the DUT divider phase: Tcy ticks are consumed at posedges where cyc becomes 4k
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (t0if_set === 1'b1) pulses <= pulses + 1;
  end

  // Drive a one-clk write so that it is captured at the posedge where cyc becomes target
  task automatic wr_at(input logic [8:0] a, input logic [7:0] d, input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc + 1 != target) && (n < 200));
    if (cyc + 1 != target) begin
      errs++;
      $display("FAIL wr_align: reached cyc %0d, required %0d", cyc + 1, target);
    end
    addr    = a;
    data_in = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    addr = 9'h081; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e || rd_hit !== 1'b1) begin
      errs++; $display("FAIL rst_option: data=%h hit=%b, required %h hit=1", data_out, rd_hit, e);
    end
    addr = 9'h001; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e || rd_hit !== 1'b1) begin
      errs++; $display("FAIL rst_tmr0: data=%h hit=%b, required %h hit=1", data_out, rd_hit, e);
    end
    addr = 9'h005; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e || rd_hit !== 1'b0) begin
      errs++; $display("FAIL rst_nodecode: data=%h hit=%b, required %h hit=0", data_out, rd_hit, e);
    end
    vecs++;
    if (t0if_set !== 1'b0) begin
      errs++; $display("FAIL rst_t0if: got %b, required 0", t0if_set);
    end
  endtask

  task automatic test_bypass_overflow();
    int p, p0;
    wr_at(9'h081, 8'h08, cyc + 2);
    wr_at(9'h001, 8'hFD, (cyc / 4 + 2) * 4 + 1);
    p = cyc; p0 = pulses;
    addr = 9'h001;
    exp_q.push_back(8'hFD);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    repeat (7) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL byp_inhibit: cyc+%0d data=%h, required %h", cyc - p, data_out, e); end
    repeat (4) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL byp_inc1: data=%h, required %h", data_out, e); end
    repeat (4) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL byp_inc2: data=%h, required %h", data_out, e); end
    repeat (4) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e || t0if_set !== 1'b1) begin
      errs++; $display("FAIL byp_wrap: data=%h t0if=%b, required %h t0if=1", data_out, t0if_set, e);
    end
    @(posedge clk); #1;
    vecs++;
    if (t0if_set !== 1'b0) begin errs++; $display("FAIL byp_pulse_end: t0if=%b, required 0", t0if_set); end
    @(negedge clk);
    vecs++;
    if (pulses - p0 !== 1) begin errs++; $display("FAIL byp_pulse_cnt: %0d pulse clks, required 1", pulses - p0); end
  endtask

  task automatic test_prescaler();
    wr_at(9'h081, 8'h02, cyc + 2);
    wr_at(9'h001, 8'h00, (cyc / 4 + 2) * 4 + 1);
    addr = 9'h001;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h05);
    repeat (11) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL pre_tick3: data=%h, required %h", data_out, e); end
    repeat (4) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL pre_tick4: data=%h, required %h", data_out, e); end
    repeat (120) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL pre_tick34: data=%h, required %h", data_out, e); end
    repeat (7) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL pre_tick35: data=%h, required %h", data_out, e); end
    @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL pre_tick36: data=%h, required %h", data_out, e); end
  endtask

  task automatic test_external();
    wr_at(9'h081, 8'h38, cyc + 2);
    wr_at(9'h001, 8'h00, cyc + 2);
    addr = 9'h001;
    repeat (12) @(posedge clk); #1;
    exp_q.push_back(8'h00);
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL ext_start: data=%h, required %h", data_out, e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); t0cki = 1'b1;
      exp_q.push_back(8'(i));
      repeat (6) @(posedge clk); #1;
      vecs++; e = exp_q.pop_front();
      if (data_out !== e) begin errs++; $display("FAIL ext_rise_ignored: edge %0d data=%h, required %h", i, data_out, e); end
      @(negedge clk); t0cki = 1'b0;
      exp_q.push_back(8'(i));
      exp_q.push_back(8'(i + 1));
      repeat (2) @(posedge clk); #1;
      vecs++; e = exp_q.pop_front();
      if (data_out !== e) begin errs++; $display("FAIL ext_early: edge %0d data=%h, required %h", i, data_out, e); end
      @(posedge clk); #1;
      vecs++; e = exp_q.pop_front();
      if (data_out !== e) begin errs++; $display("FAIL ext_latency: edge %0d data=%h, required %h", i, data_out, e); end
    end
    repeat (8) @(posedge clk); #1;
    exp_q.push_back(8'h05);
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL ext_final: data=%h, required %h", data_out, e); end
  endtask

  task automatic test_write_collision();
    int p, p0;
    wr_at(9'h081, 8'h08, cyc + 2);
    wr_at(9'h001, 8'hFF, (cyc / 4 + 2) * 4 + 1);
    p = cyc; p0 = pulses;
    addr = 9'h001;
    exp_q.push_back(8'hFF);
    repeat (10) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL col_pre: data=%h, required %h", data_out, e); end
    wr_at(9'h001, 8'h42, p + 11);
    addr = 9'h001;
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL col_write_wins: data=%h, required %h", data_out, e); end
    repeat (12) @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL col_resume: cyc+%0d data=%h, required %h", cyc - p, data_out, e); end
    vecs++;
    if (pulses - p0 !== 0) begin errs++; $display("FAIL col_no_t0if: %0d pulse clks, required 0", pulses - p0); end
  endtask

  task automatic test_decode();
    wr_at(9'h181, 8'hF8, cyc + 2);
    wr_at(9'h101, 8'h33, cyc + 2);
    wr_at(9'h005, 8'h55, cyc + 2);
    wr_at(9'h080, 8'h55, cyc + 2);
    wr_at(9'h100, 8'h55, cyc + 2);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'hF8);
    addr = 9'h001; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL dec_tmr0_alias: data=%h, required %h", data_out, e); end
    addr = 9'h081; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL dec_option_bits76: data=%h, required %h", data_out, e); end
    addr = 9'h181; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e || rd_hit !== 1'b1) begin
      errs++; $display("FAIL dec_option_alias: data=%h hit=%b, required %h hit=1", data_out, rd_hit, e);
    end
  endtask

  task automatic test_reset_mid();
    wr_at(9'h081, 8'h00, cyc + 2);
    wr_at(9'h001, 8'h7A, cyc + 2);
    addr = 9'h001;
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL rmid_before: data=%h, required %h", data_out, e); end
    rst = 1'b0; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL rmid_tmr0: data=%h, required %h", data_out, e); end
    addr = 9'h081; #1;
    vecs++; e = exp_q.pop_front();
    if (data_out !== e) begin errs++; $display("FAIL rmid_option: data=%h, required %h", data_out, e); end
    @(negedge clk); rst = 1'b1;

    wr_at(9'h081, 8'h08, cyc + 2);
    wr_at(9'h001, 8'hFF, (cyc / 4 + 2) * 4 + 1);
    repeat (11) @(posedge clk); #1;
    vecs++;
    if (t0if_set !== 1'b1) begin errs++; $display("FAIL rmid_pend_setup: t0if=%b, required 1", t0if_set); end
    rst = 1'b0; #1;
    vecs++;
    if (t0if_set !== 1'b0) begin errs++; $display("FAIL rmid_pend_cancel: t0if=%b, required 0", t0if_set); end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    vecs    = 0;
    errs    = 0;
    pulses  = 0;
    rst     = 1'b0;
    addr    = 9'h000;
    data_in = 8'h00;
    wr_en   = 1'b0;
    t0cki   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_bypass_overflow();
    test_prescaler();
    test_external();
    test_write_collision();
    test_decode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
